// File: rtl/alu_share_arb_pkg.sv
// Shared constants for alu_share_arb and the combinational alu it wraps.
package alu_share_arb_pkg;
    localparam int ALU_OP_W  = 12;
    localparam int DATA_W    = 32;

    // One-hot op bit positions
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    localparam int PORT0     = 0;
    localparam int PORT1     = 1;
    localparam int NUM_PORTS = 2;

    // True when the op vector has exactly one bit set
    function automatic logic op_is_onehot(input logic [ALU_OP_W-1:0] op);
        int cnt;
        cnt = 0;
        for (int i = 0; i < ALU_OP_W; i++) cnt += int'(op[i]);
        return (cnt == 1);
    endfunction
endpackage

// File: rtl/alu.sv
// Combinational ALU, one-hot op select. Shifts move src1 by src2[4:0]; lui passes src2.
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_src1,
    input  logic [DATA_W-1:0]   alu_src2,
    output logic [DATA_W-1:0]   alu_result
);
    logic [DATA_W-1:0] add_r, sub_r, slt_r, sltu_r, and_r, nor_r, or_r, xor_r;
    logic [DATA_W-1:0] sll_r, srl_r, sra_r, lui_r;

    // Evaluate every op in parallel, then AND-OR select by the one-hot op
    always_comb begin
        add_r  = alu_src1 + alu_src2;
        sub_r  = alu_src1 - alu_src2;
        slt_r  = {{(DATA_W-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
        sltu_r = {{(DATA_W-1){1'b0}}, (alu_src1 < alu_src2)};
        and_r  = alu_src1 & alu_src2;
        nor_r  = ~(alu_src1 | alu_src2);
        or_r   = alu_src1 | alu_src2;
        xor_r  = alu_src1 ^ alu_src2;
        sll_r  = alu_src1 << alu_src2[4:0];
        srl_r  = alu_src1 >> alu_src2[4:0];
        sra_r  = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
        lui_r  = alu_src2;
        alu_result = ({DATA_W{alu_op[OP_ADD]}}  & add_r)
                   | ({DATA_W{alu_op[OP_SUB]}}  & sub_r)
                   | ({DATA_W{alu_op[OP_SLT]}}  & slt_r)
                   | ({DATA_W{alu_op[OP_SLTU]}} & sltu_r)
                   | ({DATA_W{alu_op[OP_AND]}}  & and_r)
                   | ({DATA_W{alu_op[OP_NOR]}}  & nor_r)
                   | ({DATA_W{alu_op[OP_OR]}}   & or_r)
                   | ({DATA_W{alu_op[OP_XOR]}}  & xor_r)
                   | ({DATA_W{alu_op[OP_SLL]}}  & sll_r)
                   | ({DATA_W{alu_op[OP_SRL]}}  & srl_r)
                   | ({DATA_W{alu_op[OP_SRA]}}  & sra_r)
                   | ({DATA_W{alu_op[OP_LUI]}}  & lui_r);
    end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin two-port arbiter sharing one alu; one-entry response buffer per port.
// Optional perf counters enabled by defining ALU_SHARE_ARB_PERF_EN.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [DATA_W-1:0]   req0_src1,
    input  logic [DATA_W-1:0]   req0_src2,
    input  logic [TAG_W-1:0]    req0_tag,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [DATA_W-1:0]   req1_src1,
    input  logic [DATA_W-1:0]   req1_src2,
    input  logic [TAG_W-1:0]    req1_tag,
    output logic                resp0_valid,
    input  logic                resp0_ready,
    output logic [DATA_W-1:0]   resp0_result,
    output logic [TAG_W-1:0]    resp0_tag,
    output logic                resp0_err,
    output logic                resp1_valid,
    input  logic                resp1_ready,
    output logic [DATA_W-1:0]   resp1_result,
    output logic [TAG_W-1:0]    resp1_tag,
    output logic                resp1_err
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [31:0]         perf_grant0,
    output logic [31:0]         perf_grant1,
    output logic [31:0]         perf_conflict
`endif
);
    logic [NUM_PORTS-1:0]                    req_valid, resp_ready, accept, elig, grant;
    logic [NUM_PORTS-1:0]                    buf_valid, buf_err;
    logic [NUM_PORTS-1:0][DATA_W-1:0]        buf_result;
    logic [NUM_PORTS-1:0][TAG_W-1:0]         buf_tag;
    logic [NUM_PORTS-1:0][TAG_W-1:0]         req_tag;
    logic                                    last_grant;
    logic [ALU_OP_W-1:0]                     sel_op;
    logic [DATA_W-1:0]                       sel_src1, sel_src2, alu_res, store_result;
    logic                                    sel_err;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};
    assign req_tag    = {req1_tag, req0_tag};

    // Eligibility and round-robin grant; resetn gates so nothing is taken during reset
    always_comb begin
        accept = ~buf_valid | (buf_valid & resp_ready);
        elig   = req_valid & accept & {NUM_PORTS{resetn}};
        grant  = '0;
        grant[PORT0] = elig[PORT0] & (~elig[PORT1] | last_grant);
        grant[PORT1] = elig[PORT1] & (~elig[PORT0] | ~last_grant);
    end

    assign req0_ready = grant[PORT0];
    assign req1_ready = grant[PORT1];

    // Operand mux into the shared ALU; op is zero when nobody is granted
    always_comb begin
        sel_op   = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        if (grant[PORT0]) begin
            sel_op = req0_op; sel_src1 = req0_src1; sel_src2 = req0_src2;
        end else if (grant[PORT1]) begin
            sel_op = req1_op; sel_src1 = req1_src1; sel_src2 = req1_src2;
        end
        sel_err      = ~op_is_onehot(sel_op);
        store_result = sel_err ? '0 : alu_res;
    end

    alu u_alu (
        .alu_op     (sel_op),
        .alu_src1   (sel_src1),
        .alu_src2   (sel_src2),
        .alu_result (alu_res)
    );

    // Response buffers: a grant loads (even while draining), a bare drain clears valid
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid  <= '0;
            buf_err    <= '0;
            buf_result <= '0;
            buf_tag    <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) begin
                    buf_valid[i]  <= 1'b1;
                    buf_result[i] <= store_result;
                    buf_tag[i]    <= req_tag[i];
                    buf_err[i]    <= sel_err;
                end else if (buf_valid[i] && resp_ready[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Remember who won last; reset to 1 so port 0 takes the first conflict
    always_ff @(posedge clk) begin
        if (!resetn)      last_grant <= 1'b1;
        else if (|grant)  last_grant <= grant[PORT1];
    end

    assign resp0_valid  = buf_valid[PORT0];
    assign resp0_result = buf_result[PORT0];
    assign resp0_tag    = buf_tag[PORT0];
    assign resp0_err    = buf_err[PORT0];
    assign resp1_valid  = buf_valid[PORT1];
    assign resp1_result = buf_result[PORT1];
    assign resp1_tag    = buf_tag[PORT1];
    assign resp1_err    = buf_err[PORT1];

`ifdef ALU_SHARE_ARB_PERF_EN
    // Free-running event counters, wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant[PORT0])          perf_grant0   <= perf_grant0 + 32'd1;
            if (grant[PORT1])          perf_grant1   <= perf_grant1 + 32'd1;
            if (elig[PORT0] && elig[PORT1]) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif
endmodule
